// File: rtl/axi_pkg.sv
// Shared AXI encodings, FSM state types and the burst legality/decode check
// used by both channels of the ACP memory slave.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [2:0] SIZE_8B = 3'b011;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    // Response for a whole burst. The end address is formed in 33 bits so a
    // burst running past 32'hFFFF_FFFF decodes as out of range instead of wrapping.
    // Decode errors take priority over unsupported burst/size.
    function automatic logic [1:0] burst_resp(
        input logic [31:0] addr,
        input logic [7:0]  len,
        input logic [1:0]  burst,
        input logic [2:0]  size,
        input logic [31:0] base,
        input int unsigned depth_log2
    );
        logic [32:0] start_a;
        logic [32:0] span;
        logic [32:0] end_a;
        logic [32:0] limit;
        start_a = {1'b0, addr & ~32'h7};
        span    = (burst == BURST_FIXED) ? 33'd8 : (({25'd0, len} + 33'd1) << 3);
        end_a   = start_a + span;
        limit   = {1'b0, base} + (33'd8 << depth_log2);
        if (start_a < {1'b0, base} || end_a > limit)
            return RESP_DECERR;
        if ((burst != BURST_FIXED && burst != BURST_INCR) || size != SIZE_8B)
            return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_mem_bram.sv
// Simple dual-port 64-bit RAM with per-byte write enables and a registered,
// read-enabled output. A same-address read and write returns the old word.
module axi_mem_bram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [7:0]        we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [63:0]       wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [63:0]       rdata
);

    logic [63:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 8; b++) begin
            if (we[b])
                mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
        // Output register only updates on re, so a stalled beat keeps its data.
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/axi_acp_mem_slave.sv
// AXI 64-bit burst responder backed by block RAM; stands in for ACP as a
// fabric memory model. Read and write channels run independently.
module axi_acp_mem_slave
    import axi_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
    parameter int          DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] S_AXI_AWADDR,
    input  logic [7:0]  S_AXI_AWLEN,
    input  logic [2:0]  S_AXI_AWSIZE,
    input  logic [1:0]  S_AXI_AWBURST,
    input  logic [3:0]  S_AXI_AWCACHE,
    input  logic [2:0]  S_AXI_AWPROT,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [63:0] S_AXI_WDATA,
    input  logic [7:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WLAST,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic [7:0]  S_AXI_ARLEN,
    input  logic [2:0]  S_AXI_ARSIZE,
    input  logic [1:0]  S_AXI_ARBURST,
    input  logic [3:0]  S_AXI_ARCACHE,
    input  logic [2:0]  S_AXI_ARPROT,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic [63:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RLAST,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY,
    output w_state_e    w_state_dbg,
    output r_state_e    r_state_dbg
);

    // Handshakes: a transfer happens on a rising clk edge where VALID and READY
    // are both high; a source holds VALID and its payload until that edge.

    w_state_e    w_state;
    r_state_e    r_state;
    logic [31:0] w_addr, r_addr, r_next_addr, rd_addr;
    logic [7:0]  w_len, w_cnt, r_len, r_cnt;
    logic [1:0]  w_burst, r_burst, w_err;
    logic        w_last_err;
    logic        w_fire, ar_fire, aw_fire, r_adv;
    logic [7:0]  mem_we;
    logic        mem_re;
    logic [63:0] mem_q;
    logic [DEPTH_LOG2-1:0] w_idx, r_idx;
    logic        unused_ok;

    assign unused_ok = ^{S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_ARCACHE, S_AXI_ARPROT};

    assign w_state_dbg = w_state;
    assign r_state_dbg = r_state;

    assign aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_fire  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_fire = S_AXI_ARVALID && S_AXI_ARREADY;
    assign r_adv   = (r_state == R_DATA) && S_AXI_RREADY && !S_AXI_RLAST;

    // ---------------- write channel ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state       <= W_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
            w_addr        <= '0;
            w_len         <= '0;
            w_cnt         <= '0;
            w_burst       <= BURST_INCR;
            w_err         <= RESP_OKAY;
            w_last_err    <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    S_AXI_AWREADY <= 1'b1;
                    if (aw_fire) begin
                        S_AXI_AWREADY <= 1'b0;
                        S_AXI_WREADY  <= 1'b1;
                        w_addr        <= S_AXI_AWADDR & ~32'h7;
                        w_len         <= S_AXI_AWLEN;
                        w_burst       <= S_AXI_AWBURST;
                        w_err         <= burst_resp(S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWBURST,
                                                    S_AXI_AWSIZE, ADDR_BASE, DEPTH_LOG2);
                        w_cnt         <= '0;
                        w_last_err    <= 1'b0;
                        w_state       <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_cnt <= w_cnt + 8'd1;
                        if (w_burst == BURST_INCR)
                            w_addr <= w_addr + 32'd8;
                        // Burst length comes from AWLEN; WLAST only grades the response.
                        if (w_cnt == w_len) begin
                            S_AXI_WREADY <= 1'b0;
                            S_AXI_BVALID <= 1'b1;
                            if (w_err != RESP_OKAY)
                                S_AXI_BRESP <= w_err;
                            else if (w_last_err || !S_AXI_WLAST)
                                S_AXI_BRESP <= RESP_SLVERR;
                            else
                                S_AXI_BRESP <= RESP_OKAY;
                            w_state <= W_RESP;
                        end else if (S_AXI_WLAST) begin
                            w_last_err <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID  <= 1'b0;
                        S_AXI_BRESP   <= RESP_OKAY;
                        S_AXI_AWREADY <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    assign w_idx  = DEPTH_LOG2'((w_addr - ADDR_BASE) >> 3);
    assign mem_we = (w_fire && w_err == RESP_OKAY) ? S_AXI_WSTRB : 8'h00;

    // ---------------- read channel ----------------
    assign r_next_addr = (r_burst == BURST_INCR) ? r_addr + 32'd8 : r_addr;
    assign rd_addr     = ar_fire ? (S_AXI_ARADDR & ~32'h7) : r_next_addr;
    assign r_idx       = DEPTH_LOG2'((rd_addr - ADDR_BASE) >> 3);
    assign mem_re      = ar_fire || r_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RLAST   <= 1'b0;
            S_AXI_RRESP   <= RESP_OKAY;
            r_addr        <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_burst       <= BURST_INCR;
        end else begin
            case (r_state)
                R_IDLE: begin
                    S_AXI_ARREADY <= 1'b1;
                    if (ar_fire) begin
                        S_AXI_ARREADY <= 1'b0;
                        S_AXI_RVALID  <= 1'b1;
                        S_AXI_RLAST   <= (S_AXI_ARLEN == 8'd0);
                        S_AXI_RRESP   <= burst_resp(S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST,
                                                    S_AXI_ARSIZE, ADDR_BASE, DEPTH_LOG2);
                        r_addr        <= S_AXI_ARADDR & ~32'h7;
                        r_len         <= S_AXI_ARLEN;
                        r_burst       <= S_AXI_ARBURST;
                        r_cnt         <= '0;
                        r_state       <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        if (S_AXI_RLAST) begin
                            S_AXI_RVALID  <= 1'b0;
                            S_AXI_RLAST   <= 1'b0;
                            S_AXI_RRESP   <= RESP_OKAY;
                            S_AXI_ARREADY <= 1'b1;
                            r_state       <= R_IDLE;
                        end else begin
                            r_cnt       <= r_cnt + 8'd1;
                            r_addr      <= r_next_addr;
                            S_AXI_RLAST <= (r_cnt + 8'd1 == r_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Error bursts and idle cycles present zero data.
    assign S_AXI_RDATA = (S_AXI_RVALID && S_AXI_RRESP == RESP_OKAY) ? mem_q : 64'd0;

    axi_mem_bram #(.ADDR_W(DEPTH_LOG2)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (w_idx),
        .wdata (S_AXI_WDATA),
        .re    (mem_re),
        .raddr (r_idx),
        .rdata (mem_q)
    );

endmodule

// File: doc/axi_acp_mem_slave.md
AXI_ACP_MEM_SLAVE -- requirements
Module: axi_acp_mem_slave

Interface
REQ-001 Parameter ADDR_BASE, 32'h0000_0000, byte base address of the memory window.
REQ-002 Parameter DEPTH_LOG2, 10, log2 of the number of 64-bit words; default is 1024 words (8 KiB).
REQ-003 Port clk, in, 1, single clock for all logic.
REQ-004 Port rst_n, in, 1; reset is asynchronous and active-low.
REQ-005 Write address ports: S_AXI_AWADDR in 32; AWLEN in 8; AWSIZE in 3; AWBURST in 2; AWCACHE in 4; AWPROT in 3; AWVALID in 1; AWREADY out 1.
REQ-006 Write data ports: S_AXI_WDATA in 64; WSTRB in 8; WLAST in 1; WVALID in 1; WREADY out 1.
REQ-007 Write response ports: S_AXI_BRESP out 2; BVALID out 1; BREADY in 1.
REQ-008 Read address ports: S_AXI_ARADDR in 32; ARLEN in 8; ARSIZE in 3; ARBURST in 2; ARCACHE in 4; ARPROT in 3; ARVALID in 1; ARREADY out 1.
REQ-009 Read data ports: S_AXI_RDATA out 64; RRESP out 2; RLAST out 1; RVALID out 1; RREADY in 1.

Function
REQ-010 The block SHALL be the responder end of the accelerator's 64-bit AXI burst master port; it SHALL be usable as a fabric memory model in place of ACP.
REQ-011 Read and write channels SHALL run independently and concurrently.
REQ-012 The write FSM SHALL have states W_IDLE, W_DATA and W_RESP.
- W_IDLE: AWREADY=1; an AW handshake latches address, length and burst type, then moves to W_DATA.
- W_DATA: WREADY=1; each W handshake writes one beat.
- W_RESP: BVALID=1 until BREADY, then returns to W_IDLE.
REQ-013 Write data SHALL be applied per byte under WSTRB; a beat with WSTRB=0 SHALL leave memory unchanged.
REQ-014 The write FSM SHALL leave W_DATA after beat AWLEN+1, counted by beat count; BVALID SHALL assert the cycle after the final W handshake.
REQ-015 If WLAST does not coincide with the final counted beat, BRESP SHALL be SLVERR (2'b10); all counted beats SHALL still be written.
REQ-016 The read FSM SHALL have states R_IDLE and R_DATA.
- R_IDLE: ARREADY=1; an AR handshake latches the request and moves to R_DATA.
- First RVALID SHALL assert exactly 1 cycle after the AR handshake.
- Subsequent beats SHALL be issued back-to-back while RREADY=1.
- RDATA, RRESP and RLAST SHALL hold stable while RVALID=1 and RREADY=0.
- RLAST SHALL be 1 only on beat ARLEN+1; the FSM returns to R_IDLE after that handshake.
REQ-017 Address increment:
- INCR: +8 per beat; addresses SHALL be aligned down to 8 bytes.
- FIXED: the same word every beat.
REQ-018 Error responses:
- AxBURST=WRAP or AxSIZE≠3'b011: SLVERR for the whole burst.
- Any beat address outside [ADDR_BASE, ADDR_BASE+8·2^DEPTH_LOG2): DECERR (2'b11) for the whole burst.
- In both cases no memory write SHALL occur, and RDATA SHALL be 0.
- Error bursts SHALL still consume all W beats and deliver all R beats with correct RLAST.
REQ-019 The range check SHALL use a 33-bit end-address computation so that a burst crossing 32'hFFFF_FFFF SHALL yield DECERR, not wrap.
REQ-020 On a same-cycle read and write to the same word, the read SHALL return the pre-write data (read-first).
REQ-021 AxCACHE and AxPROT SHALL be accepted and ignored.
REQ-022 RESP SHALL be OKAY (2'b00) in all cases not covered by REQ-015 or REQ-018.

Reset
REQ-023 On rst_n=0, asynchronously:
- AWREADY=0, WREADY=0, BVALID=0, BRESP=0.
- ARREADY=0, RVALID=0, RLAST=0, RRESP=0, RDATA=0.
- Both FSMs go to IDLE; beat counters clear.
REQ-024 AWREADY and ARREADY SHALL assert on the first clk edge after rst_n deasserts.
REQ-025 Memory contents SHALL NOT be cleared by reset.
REQ-026 Reset mid-burst SHALL abandon the burst; no B or R beat for it SHALL be issued after release.

Structure
REQ-027 A shared package axi_pkg SHALL hold:
- RESP_OKAY/EXOKAY/SLVERR/DECERR;
- BURST_FIXED/INCR/WRAP;
- SIZE_8B;
- the write and read FSM state enums.
REQ-028 Storage SHALL be one sub-module, axi_mem_bram: simple dual-port, 64-bit, 8 byte-write-enables, 1-cycle registered read, inferable as block RAM.

Verification
REQ-029 Write INCR AWADDR=0x40, AWLEN=3, data 0x1..0x4, WSTRB=0xFF, then read the same range -> BRESP=OKAY; RDATA 0x1,0x2,0x3,0x4; RLAST on beat 4; first RVALID 1 cycle after AR.
REQ-030 Write to 0x0 with WSTRB=0x0F and data 0xAAAA_AAAA_BBBB_BBBB over 0 -> readback 0x0000_0000_BBBB_BBBB.
REQ-031 ARADDR=ADDR_BASE+0x1FF8, ARLEN=1 (default depth) -> two beats, RRESP=DECERR on both, RDATA=0, RLAST on beat 2.
REQ-032 AWLEN=3 with WLAST on beat 2 -> 4 beats accepted, BRESP=SLVERR; AWBURST=WRAP -> SLVERR with memory unchanged.
REQ-033 RREADY toggled randomly during an ARLEN=15 read -> 16 beats in order, stable while stalled; a concurrent write to another word completes unaffected.
REQ-034 rst_n pulsed low mid-write-burst -> all outputs 0 immediately; AWREADY=1 one cycle after release; no stray BVALID.
